cs30_top_core: RTL and testbench

- Top-level control/status core of the CS30 FPGA.
- Acts as a MIB slave on the 16-bit multiplexed address/data board bus.
- Exposes a small 32-bit register file: ID, scratch, inverted-scratch and control.
- Drives a heartbeat LED and a software-controlled check LED.
- Everything runs in one clock domain, CLK.

---
 rtl/cs30_top_core_if.sv | 28 ++
 rtl/cs30_top_core.sv | 167 ++++++++++++++++
 tb/tb_cs30_top_core.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cs30_top_core_if.sv
// ---------------------------------------------------------------------------
// cs30_top_core_if
// Groups the MIB board-bus signals shared by a bus master and the CS30 core.
//   i_mib_start      master -> slave  one-cycle pulse in address phase 1
//   i_mib_rd_wr_n    master -> slave  1 = read, 0 = write (valid with start)
//   i_mib_ad         master -> slave  address / write data, 16 bits
//   o_mib_ad         slave  -> master read data, 16 bits
//   o_mib_ad_oe      slave  -> master 1 while the slave drives the bus
//   o_mib_slave_ack  slave  -> master write-accept / read-data-valid strobe
// ---------------------------------------------------------------------------
interface cs30_top_core_if;
    logic        i_mib_start;
    logic        i_mib_rd_wr_n;
    logic [15:0] i_mib_ad;
    logic [15:0] o_mib_ad;
    logic        o_mib_ad_oe;
    logic        o_mib_slave_ack;

    modport master (
        output i_mib_start, i_mib_rd_wr_n, i_mib_ad,
        input  o_mib_ad, o_mib_ad_oe, o_mib_slave_ack
    );

    modport slave (
        input  i_mib_start, i_mib_rd_wr_n, i_mib_ad,
        output o_mib_ad, o_mib_ad_oe, o_mib_slave_ack
    );
endinterface

// File: rtl/cs30_top_core.sv
// ---------------------------------------------------------------------------
// cs30_top_core
// Control/status core of the CS30 FPGA: a MIB slave on the 16-bit multiplexed
// board bus exposing ID, SCRATCH, NSCRATCH and CTRL registers, plus a
// heartbeat LED and a software-controlled check LED.
// Ports:
//   CLK          system clock, rising edge
//   i_srst       synchronous active-high reset
//   mib          MIB bus (slave modport of cs30_top_core_if)
//   o_led        heartbeat, toggles every P_HB_DIV cycles
//   o_led_check  CTRL[0]
// ---------------------------------------------------------------------------
module cs30_top_core #(
    parameter logic [3:0]  P_MIB_MSN  = 4'h0,
    parameter logic [31:0] P_ID_VALUE = 32'hC530_0001,
    parameter int          P_HB_DIV   = 25_000_000
) (
    input  logic                  CLK,
    input  logic                  i_srst,
    cs30_top_core_if.slave        mib,
    output logic                  o_led,
    output logic                  o_led_check
);

    localparam int              HB_W    = $clog2(P_HB_DIV);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(P_HB_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR2, S_WDATA1, S_WDATA2, S_WACK, S_RTURN, S_RDATA1, S_RDATA2
    } state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic [7:0]  addr_hi_q, addr_hi_d;
    logic [15:2] addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] scratch_q, scratch_d;
    logic        ctrl_q, ctrl_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic        led_q, led_d;
    logic [15:0] ad_q, ad_d;
    logic        oe_q, oe_d;
    logic        ack_q, ack_d;
    logic [17:0] reg_idx;
    logic [31:0] rdata_sel;
    logic        hb_wrap;

    // Word index into the register map; addr[1:0] are never stored.
    assign reg_idx = {addr_hi_q[3:0], addr_lo_q};

    always_comb begin
        rdata_sel = 32'hDEAD_BEEF;
        case (reg_idx)
            18'd0:   rdata_sel = P_ID_VALUE;
            18'd1:   rdata_sel = scratch_q;
            18'd2:   rdata_sel = ~scratch_q;
            18'd3:   rdata_sel = {31'd0, ctrl_q};
            default: rdata_sel = 32'hDEAD_BEEF;
        endcase
    end

    // State register plus all datapath and output flops.
    always_ff @(posedge CLK) begin
        if (i_srst) begin
            state_q   <= S_IDLE;
            rd_q      <= 1'b0;
            addr_hi_q <= '0;
            addr_lo_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            scratch_q <= '0;
            ctrl_q    <= 1'b0;
            hb_cnt_q  <= '0;
            led_q     <= 1'b0;
            ad_q      <= '0;
            oe_q      <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            addr_hi_q <= addr_hi_d;
            addr_lo_q <= addr_lo_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            hb_cnt_q  <= hb_cnt_d;
            led_q     <= led_d;
            ad_q      <= ad_d;
            oe_q      <= oe_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state logic. A foreign slave select is rejected once the full
    // address is known, without ever acking or driving the bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mib.i_mib_start) state_d = S_ADDR2;
            S_ADDR2: begin
                if (addr_hi_q[7:4] != P_MIB_MSN) state_d = S_IDLE;
                else if (rd_q)                   state_d = S_RTURN;
                else                             state_d = S_WDATA1;
            end
            S_WDATA1: state_d = S_WDATA2;
            S_WDATA2: state_d = S_WACK;
            S_WACK:   state_d = S_IDLE;
            S_RTURN:  state_d = S_RDATA1;
            S_RDATA1: state_d = S_RDATA2;
            S_RDATA2: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath captures, register writes and the heartbeat counter. The
    // register write lands on the edge that ends the ack cycle.
    always_comb begin
        rd_d      = rd_q;
        addr_hi_d = addr_hi_q;
        addr_lo_d = addr_lo_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        case (state_q)
            S_IDLE: begin
                if (mib.i_mib_start) begin
                    rd_d      = mib.i_mib_rd_wr_n;
                    addr_hi_d = mib.i_mib_ad[7:0];
                end
            end
            S_ADDR2:  addr_lo_d = mib.i_mib_ad[15:2];
            S_WDATA1: wdata_d[31:16] = mib.i_mib_ad;
            S_WDATA2: wdata_d[15:0]  = mib.i_mib_ad;
            S_WACK: begin
                if (reg_idx == 18'd1) scratch_d = wdata_q;
                if (reg_idx == 18'd3) ctrl_d    = wdata_q[0];
            end
            S_RTURN:  rdata_d = rdata_sel;
            default:  ;
        endcase

        hb_wrap  = (hb_cnt_q == HB_LAST);
        hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + HB_W'(1);
        led_d    = led_q ^ hb_wrap;
    end

    // Output logic, decoded from the next state so the flops present each
    // state's values during that state's own cycle. The upper read half is
    // taken straight from the selector because rdata_q loads on the same edge.
    always_comb begin
        ack_d = (state_d == S_WACK) || (state_d == S_RDATA1) || (state_d == S_RDATA2);
        oe_d  = (state_d == S_RDATA1) || (state_d == S_RDATA2);
        ad_d  = 16'h0000;
        if (state_d == S_RDATA1)      ad_d = rdata_sel[31:16];
        else if (state_d == S_RDATA2) ad_d = rdata_q[15:0];
    end

    assign mib.o_mib_ad        = ad_q;
    assign mib.o_mib_ad_oe     = oe_q;
    assign mib.o_mib_slave_ack = ack_q;
    assign o_led               = led_q;
    assign o_led_check         = ctrl_q;

endmodule

// File: tb/tb_cs30_top_core.sv
// ---------------------------------------------------------------------------
// tb_cs30_top_core
// Self-checking bench for cs30_top_core: directed vector table, hand-written
// reset/heartbeat sequences, and random transfers checked against a
// register-map model.
// ---------------------------------------------------------------------------
module tb_cs30_top_core;

    logic CLK;
    logic i_srst;
    logic o_led;
    logic o_led_check;

    cs30_top_core_if mib();

    cs30_top_core #(
        .P_MIB_MSN (4'h0),
        .P_ID_VALUE(32'hC530_0001),
        .P_HB_DIV  (4)
    ) dut (
        .CLK        (CLK),
        .i_srst     (i_srst),
        .mib        (mib),
        .o_led      (o_led),
        .o_led_check(o_led_check)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: the two writable registers.
    logic [31:0] model_scratch;
    logic        model_ctrl;

    typedef struct {
        bit          rd;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_led;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] modelRead(input logic [23:0] a);
        logic [17:0] w;
        w = a[19:2];
        if (w == 18'd0) return 32'hC530_0001;
        if (w == 18'd1) return model_scratch;
        if (w == 18'd2) return ~model_scratch;
        if (w == 18'd3) return {31'd0, model_ctrl};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic modelWrite(input logic [23:0] a, input logic [31:0] d);
        if (a[23:20] == 4'h0) begin
            if (a[19:2] == 18'd1) model_scratch = d;
            if (a[19:2] == 18'd3) model_ctrl    = d[0];
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete bus transfer. Index c of the masks is the cycle number
    // counted from the start pulse (cycle 0).
    task automatic applyStimulus(input bit rd, input logic [23:0] addr, input logic [31:0] wdata,
                                 input bit rst_at3,
                                 output logic [7:0] ack_m, output logic [7:0] oe_m,
                                 output logic [31:0] rdata, output bit ad_leak,
                                 output bit led_ack, output bit led_after);
        logic [7:0] junk;
        ack_m = '0; oe_m = '0; rdata = '0; ad_leak = 1'b0; led_ack = 1'b0; led_after = 1'b0;
        junk = 8'($urandom);
        @(negedge CLK);
        mib.i_mib_start   = 1'b1;
        mib.i_mib_rd_wr_n = rd;
        mib.i_mib_ad      = {junk, addr[23:16]};
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            ack_m[c] = mib.o_mib_slave_ack;
            oe_m[c]  = mib.o_mib_ad_oe;
            if (!mib.o_mib_ad_oe && mib.o_mib_ad != 16'h0000) ad_leak = 1'b1;
            if (c == 3) rdata[31:16] = mib.o_mib_ad;
            if (c == 4) begin rdata[15:0] = mib.o_mib_ad; led_ack = o_led_check; end
            if (c == 5) led_after = o_led_check;
            // Stray starts in busy states must be ignored.
            mib.i_mib_start   = (c == 2 || c == 3) && !rst_at3 && addr[23:20] == 4'h0;
            mib.i_mib_rd_wr_n = 1'($urandom);
            case (c)
                1:       mib.i_mib_ad = addr[15:0];
                2:       mib.i_mib_ad = wdata[31:16];
                3:       mib.i_mib_ad = wdata[15:0];
                default: mib.i_mib_ad = 16'($urandom);
            endcase
            if (rst_at3 && c == 3) i_srst = 1'b1;
            if (c == 4) i_srst = 1'b0;
        end
        mib.i_mib_start = 1'b0;
    endtask

    // Runs one transfer and compares every observable against the rules of
    // the bus protocol plus the supplied expected read data / check LED.
    task automatic runVector(input string tag, input bit rd, input logic [23:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input bit exp_led);
        logic [7:0]  ack_m, oe_m, exp_ack, exp_oe;
        logic [31:0] rdata;
        bit          leak, led_ack, led_after, prev_led;
        bit          valid;
        prev_led = model_ctrl;
        valid = (addr[23:20] == 4'h0);
        applyStimulus(rd, addr, wdata, 1'b0, ack_m, oe_m, rdata, leak, led_ack, led_after);
        exp_ack = !valid ? 8'h00 : (rd ? 8'b0001_1000 : 8'b0001_0000);
        exp_oe  = (valid && rd) ? 8'b0001_1000 : 8'h00;
        checkOutput({tag, " ack"}, 32'(ack_m), 32'(exp_ack));
        checkOutput({tag, " oe"}, 32'(oe_m), 32'(exp_oe));
        checkOutput({tag, " idle_ad"}, 32'(leak), 32'd0);
        if (valid && rd) checkOutput({tag, " rdata"}, rdata, exp_rdata);
        if (!rd) modelWrite(addr, wdata);
        if (valid && !rd && addr[19:2] == 18'd3)
            checkOutput({tag, " led_at_ack"}, 32'(led_ack), 32'(prev_led));
        checkOutput({tag, " led_check"}, 32'(led_after), 32'(exp_led));
    endtask

    initial begin
        logic [7:0]  ack_m, oe_m;
        logic [31:0] rdata;
        bit          leak, led_ack, led_after;
        logic [23:0] raddrs[10];

        i_srst = 1'b1;
        mib.i_mib_start = 1'b0;
        mib.i_mib_rd_wr_n = 1'b0;
        mib.i_mib_ad = 16'h0000;
        model_scratch = 32'h0;
        model_ctrl = 1'b0;

        vecs[0]  = '{1, 24'h000000, 32'h0,        32'hC530_0001, 0};
        vecs[1]  = '{0, 24'h000004, 32'h0101_0202, 32'h0,        0};
        vecs[2]  = '{1, 24'h000004, 32'h0,        32'h0101_0202, 0};
        vecs[3]  = '{1, 24'h000008, 32'h0,        32'hFEFE_FDFD, 0};
        vecs[4]  = '{0, 24'h00000C, 32'h0000_0001, 32'h0,        1};
        vecs[5]  = '{1, 24'h00000C, 32'h0,        32'h0000_0001, 1};
        vecs[6]  = '{0, 24'h100004, 32'h5A5A_A5A5, 32'h0,        1};
        vecs[7]  = '{1, 24'h100004, 32'h0,        32'h0,         1};
        vecs[8]  = '{1, 24'h000004, 32'h0,        32'h0101_0202, 1};
        vecs[9]  = '{1, 24'h000040, 32'h0,        32'hDEAD_BEEF, 1};
        vecs[10] = '{0, 24'h000000, 32'h1234_5678, 32'h0,        1};
        vecs[11] = '{1, 24'h000000, 32'h0,        32'hC530_0001, 1};
        vecs[12] = '{1, 24'h000007, 32'h0,        32'h0101_0202, 1};
        vecs[13] = '{0, 24'h00000C, 32'h0000_0000, 32'h0,        0};
        vecs[14] = '{1, 24'h00000C, 32'h0,        32'h0000_0000, 0};
        vecs[15] = '{0, 24'h00000C, 32'hFFFF_FFFE, 32'h0,        0};

        // Reset state.
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset ack", 32'(mib.o_mib_slave_ack), 32'd0);
        checkOutput("reset oe", 32'(mib.o_mib_ad_oe), 32'd0);
        checkOutput("reset ad", 32'(mib.o_mib_ad), 32'd0);
        checkOutput("reset led", 32'(o_led), 32'd0);
        checkOutput("reset led_check", 32'(o_led_check), 32'd0);
        i_srst = 1'b0;

        // Directed table.
        for (int i = 0; i < 16; i++)
            runVector($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_rdata, vecs[i].exp_led);

        // Reset during WDATA2 of a SCRATCH write: no ack, SCRATCH cleared.
        runVector("pre_rst_wr", 1'b0, 24'h000004, 32'h7777_8888, 32'h0, 1'b0);
        applyStimulus(1'b0, 24'h000004, 32'hAAAA_5555, 1'b1, ack_m, oe_m, rdata, leak, led_ack, led_after);
        checkOutput("rst_mid ack", 32'(ack_m), 32'd0);
        checkOutput("rst_mid oe", 32'(oe_m), 32'd0);
        model_scratch = 32'h0;
        model_ctrl = 1'b0;
        runVector("post_rst_rd", 1'b1, 24'h000004, 32'h0, 32'h0, 1'b0);

        // Heartbeat from a fresh reset: toggles every 4 cycles.
        @(negedge CLK);
        i_srst = 1'b1;
        @(negedge CLK);
        checkOutput("hb k1", 32'(o_led), 32'd0);
        i_srst = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("hb k%0d", k), 32'(o_led), 32'(((k - 1) / 4) % 2));
        end

        // Random transfers against the model.
        raddrs = '{24'h000000, 24'h000004, 24'h000008, 24'h00000C, 24'h000010,
                   24'h0FFFFC, 24'h100004, 24'hF0000C, 24'h00000D, 24'h012344};
        for (int n = 0; n < 60; n++) begin
            bit          rd;
            logic [23:0] a;
            logic [31:0] d;
            logic [31:0] exp_r;
            bit          exp_l;
            rd = 1'($urandom);
            a  = raddrs[$urandom_range(0, 9)];
            d  = $urandom;
            exp_r = modelRead(a);
            exp_l = model_ctrl;
            if (!rd && a[23:20] == 4'h0 && a[19:2] == 18'd3) exp_l = d[0];
            runVector($sformatf("rnd%0d", n), rd, a, d, exp_r, exp_l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
